mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: drives the data bus, formats loads
// and fills the MEM/WB registers, stalling upstream while the bus is busy.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PIP_read_mem_i,
    input  logic        PIP_write_mem_i,
    input  logic [31:0] PIP_alu_result_i,
    input  logic [31:0] PIP_second_operand_i,
    input  logic [2:0]  PIP_funct3_i,
    input  logic        PIP_use_mem_i,
    input  logic        PIP_write_reg_i,
    input  logic [4:0]  PIP_rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        PIP_use_mem_o,
    output logic        PIP_write_reg_o,
    output logic [4:0]  PIP_rd_o,
    output logic [31:0] PIP_alu_result_o,
    output logic [31:0] PIP_mem_data_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        bus_error_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [CNT_W-1:0] cnt;

    logic        pending;
    logic        is_store;
    logic        misaligned;
    logic        req;
    logic        ack;
    logic        timeout_hit;
    logic        stall;
    logic        bubble;
    logic [1:0]  ofs;

    logic        use_mem_p1;
    logic        write_reg_p1;
    logic [4:0]  rd_p1;
    logic [31:0] alu_result_p1;
    logic [31:0] mem_data_p1;
    logic        misaligned_p1;
    logic        bus_error_p1;

    // Sign/zero extension of the addressed byte or halfword of a read word.
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  byte_ofs,
                                                input logic [31:0] word);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {byte_ofs, 3'b000};
        b = shifted[7:0];
        h = byte_ofs[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b100:  format_load = {24'b0, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b101:  format_load = {16'b0, h};
            default: format_load = word;
        endcase
    endfunction

    assign ofs      = PIP_alu_result_i[1:0];
    assign pending  = PIP_read_mem_i | PIP_write_mem_i;
    assign is_store = PIP_write_mem_i;

    always_comb begin
        misaligned = 1'b0;
        if (PIP_funct3_i[1:0] == 2'b01)
            misaligned = ofs[0];
        else if (PIP_funct3_i[1:0] == 2'b10)
            misaligned = (ofs != 2'b00);
    end

    // Reset overrides the handshake so an in-flight access is abandoned at once.
    assign req         = reset_n & (((state == IDLE) & pending & ~misaligned) | (state == BUSY));
    assign ack         = req & dmem_ack_i;
    assign timeout_hit = reset_n & (state == BUSY) & ~dmem_ack_i & (cnt == CNT_LAST);
    assign stall       = req & ~dmem_ack_i & ~timeout_hit;
    assign bubble      = stall | timeout_hit | ((state == IDLE) & pending & misaligned);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req && !dmem_ack_i) state_next = BUSY;
            BUSY:    if (dmem_ack_i || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = PIP_second_operand_i;
        if (is_store) begin
            case (PIP_funct3_i[1:0])
                2'b00: begin
                    dmem_be_o    = 4'b0001 << ofs;
                    dmem_wdata_o = {4{PIP_second_operand_i[7:0]}};
                end
                2'b01: begin
                    dmem_be_o    = 4'b0011 << ofs;
                    dmem_wdata_o = {2{PIP_second_operand_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign dmem_req_o  = req;
    assign dmem_we_o   = is_store;
    assign dmem_addr_o = {PIP_alu_result_i[31:2], 2'b00};
    assign stall_o     = stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == BUSY && state_next == BUSY) ? cnt + 1'b1 : '0;
        end
    end

    // MEM/WB boundary
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            use_mem_p1    <= 1'b0;
            write_reg_p1  <= 1'b0;
            rd_p1         <= '0;
            alu_result_p1 <= '0;
            mem_data_p1   <= '0;
            misaligned_p1 <= 1'b0;
            bus_error_p1  <= 1'b0;
        end else begin
            misaligned_p1 <= (state == IDLE) & pending & misaligned;
            bus_error_p1  <= timeout_hit;
            if (bubble) begin
                use_mem_p1    <= 1'b0;
                write_reg_p1  <= 1'b0;
                rd_p1         <= '0;
                alu_result_p1 <= '0;
                mem_data_p1   <= '0;
            end else begin
                use_mem_p1    <= PIP_use_mem_i;
                write_reg_p1  <= PIP_write_reg_i;
                rd_p1         <= PIP_rd_i;
                alu_result_p1 <= PIP_alu_result_i;
                mem_data_p1   <= ack ? format_load(PIP_funct3_i, ofs, dmem_rdata_i) : 32'h0;
            end
        end
    end

    assign PIP_use_mem_o    = use_mem_p1;
    assign PIP_write_reg_o  = write_reg_p1;
    assign PIP_rd_o         = rd_p1;
    assign PIP_alu_result_o = alu_result_p1;
    assign PIP_mem_data_o   = mem_data_p1;
    assign misaligned_o     = misaligned_p1;
    assign bus_error_o      = bus_error_p1;

endmodule
